wb_stage_buffer: RTL and testbench
==================================

WB_STAGE_BUFFER -- requirements
Module: wb_stage_buffer

Interface
REQ-001 Parameter DATA_W, default 32, sets the width of the result and read-data paths.
REQ-002 Parameter RD_W, default 5, sets the destination register index width.
REQ-003 Parameter SKID, default 1, selects the buffer mode: 1 = two-entry skid buffer, 0 = single register.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream (memory stage) entry present.
REQ-008 in_ready  output  1  buffer can accept an entry this cycle.
REQ-009 in_result  input  DATA_W  ALU/address result.
REQ-010 in_read_data  input  DATA_W  data-cache read data.
REQ-011 in_rd  input  RD_W  destination register index.
REQ-012 in_mem_to_reg  input  1  1 = write back read data, 0 = write back result.
REQ-013 in_reg_write  input  1  register-file write request.
REQ-014 out_valid  output  1  head entry present.
REQ-015 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-016 out_wb_data  output  DATA_W  selected write-back value of the head entry.
REQ-017 out_rd  output  RD_W  head destination index.
REQ-018 out_reg_write  output  1  qualified register-file write enable.

Function
REQ-019 Accept = in_valid & in_ready & ~flush; Consume = out_valid & out_ready.
REQ-020 The write-back mux is applied at capture: stored data = in_mem_to_reg ? in_read_data : in_result.
REQ-021 Stored write enable = in_reg_write & (in_rd != 0); a write to register 0 is never issued.
REQ-022 out_reg_write = out_valid & stored write enable of the head entry.
REQ-023 Latency: an entry accepted at edge N appears on the outputs after edge N when the buffer was empty or consumed in that same cycle.
REQ-024 SKID=1: in_ready is a pure register output, equal to "skid slot empty", with no combinational path from out_ready.
REQ-025 SKID=1: on accept, the entry loads the head slot if the head is empty or being consumed, otherwise it loads the skid slot.
REQ-026 SKID=1: on consume with the skid slot full, the skid entry moves to the head slot in the same edge, and any simultaneous accept loads the skid slot.
REQ-027 SKID=1: a full buffer (both slots valid) deasserts in_ready; an accept is impossible and no entry is lost or duplicated.
REQ-028 SKID=0: in_ready = ~out_valid | out_ready (combinational); simultaneous consume and accept replaces the head with no bubble.
REQ-029 Entries leave in strict FIFO order; at most 2 (SKID=1) or 1 (SKID=0) entries are held.
REQ-030 flush: at the next edge all slots become invalid and any same-cycle in_valid is dropped; flush outranks accept and consume.
REQ-031 Data/rd fields of invalid slots hold their last value and are never driven to X.
REQ-032 in_ready is 1 in the cycle following a flush.

Reset
REQ-033 While reset is high, out_valid = 0, out_reg_write = 0, out_wb_data = 0, out_rd = 0, both slots are invalid, and in_ready = 1 (SKID=1) or follows REQ-028.
REQ-034 Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
REQ-035 After reset deasserts, the first accept behaves as on an empty buffer.

Verification
REQ-036 Load, mem_to_reg=1, result=0x10, read_data=0xCAFEBABE, rd=3, out_ready=1 -> next cycle out_wb_data=0xCAFEBABE, out_rd=3, out_reg_write=1.
REQ-037 reg_write=1, rd=0 -> out_valid=1, out_reg_write=0.
REQ-038 SKID=1, out_ready=0, entries A, B, C offered back-to-back -> A held at the head, B in the skid slot, in_ready=0, C stalled; out_ready=1 -> A, B, C delivered in order on consecutive cycles.
REQ-039 Buffer holds 2 entries, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered entry never appears.
REQ-040 reset pulsed asynchronously between edges while the buffer is full -> out_valid and out_reg_write fall to 0 before the next edge.
REQ-041 SKID=0, out_ready held at 1, continuous stream -> one entry delivered per cycle with no bubbles.

Source files
------------

// File: rtl/wb_stage_buffer_if.sv
// Handshake bundle between the memory stage, the write-back buffer and the
// register-file write port.
interface wb_stage_buffer_if #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic [DATA_W-1:0] in_read_data;
   logic [RD_W-1:0]   in_rd;
   logic              in_mem_to_reg;
   logic              in_reg_write;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_wb_data;
   logic [RD_W-1:0]   out_rd;
   logic              out_reg_write;

   // Producer/consumer side: drives the upstream entry and downstream ready.
   modport master (
      output in_valid, in_result, in_read_data, in_rd, in_mem_to_reg, in_reg_write,
      output out_ready,
      input  in_ready, out_valid, out_wb_data, out_rd, out_reg_write
   );

   // Buffer side.
   modport slave (
      input  in_valid, in_result, in_read_data, in_rd, in_mem_to_reg, in_reg_write,
      input  out_ready,
      output in_ready, out_valid, out_wb_data, out_rd, out_reg_write
   );
endinterface

// File: rtl/wb_stage_buffer.sv
// Write-back stage buffer. The write-back mux and the rd==0 write suppression
// are resolved at capture, so the head slot already holds the final value.
// SKID=1 gives a two-entry skid buffer with a registered in_ready;
// SKID=0 gives a single pipeline register with a combinational in_ready.
module wb_stage_buffer #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter bit SKID   = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   wb_stage_buffer_if.slave   bus
);

   logic              head_valid;
   logic [DATA_W-1:0] head_data;
   logic [RD_W-1:0]   head_rd;
   logic              head_we;

   logic              in_ready;
   logic              accept;
   logic              consume;
   logic [DATA_W-1:0] cap_data;
   logic              cap_we;

   assign cap_data = bus.in_mem_to_reg ? bus.in_read_data : bus.in_result;
   assign cap_we   = bus.in_reg_write & (bus.in_rd != '0);
   assign accept   = bus.in_valid & in_ready & ~flush;
   assign consume  = head_valid & bus.out_ready;

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = head_valid;
   assign bus.out_wb_data   = head_data;
   assign bus.out_rd        = head_rd;
   assign bus.out_reg_write = head_valid & head_we;

   generate
      if (SKID) begin : g_skid
         logic              skid_valid;
         logic [DATA_W-1:0] skid_data;
         logic [RD_W-1:0]   skid_rd;
         logic              skid_we;

         // Ready only depends on the skid slot, which breaks the out_ready path.
         assign in_ready = ~skid_valid;

         // Head/skid slot update: skid drains into head first, new entries
         // fill the first free slot behind it.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               head_valid <= 1'b0;
               head_data  <= '0;
               head_rd    <= '0;
               head_we    <= 1'b0;
               skid_valid <= 1'b0;
               skid_data  <= '0;
               skid_rd    <= '0;
               skid_we    <= 1'b0;
            end else if (flush) begin
               head_valid <= 1'b0;
               skid_valid <= 1'b0;
            end else if (consume && skid_valid) begin
               head_valid <= 1'b1;
               head_data  <= skid_data;
               head_rd    <= skid_rd;
               head_we    <= skid_we;
               skid_valid <= accept;
               if (accept) begin
                  skid_data <= cap_data;
                  skid_rd   <= bus.in_rd;
                  skid_we   <= cap_we;
               end
            end else if (!head_valid || consume) begin
               head_valid <= accept;
               if (accept) begin
                  head_data <= cap_data;
                  head_rd   <= bus.in_rd;
                  head_we   <= cap_we;
               end
            end else if (accept) begin
               skid_valid <= 1'b1;
               skid_data  <= cap_data;
               skid_rd    <= bus.in_rd;
               skid_we    <= cap_we;
            end
         end
      end else begin : g_reg
         // A consumed head can be replaced in the same cycle, so no bubble.
         assign in_ready = ~head_valid | bus.out_ready;

         // Single-register update: load on accept, empty on a bare consume.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               head_valid <= 1'b0;
               head_data  <= '0;
               head_rd    <= '0;
               head_we    <= 1'b0;
            end else if (flush) begin
               head_valid <= 1'b0;
            end else if (accept) begin
               head_valid <= 1'b1;
               head_data  <= cap_data;
               head_rd    <= bus.in_rd;
               head_we    <= cap_we;
            end else if (consume) begin
               head_valid <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_wb_stage_buffer.sv
// Bench for wb_stage_buffer: one SKID=1 and one SKID=0 instance see the same
// stimulus; a queue model per instance predicts every output each cycle.
module tb_wb_stage_buffer;
   localparam int DATA_W = 32;
   localparam int RD_W   = 5;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [RD_W-1:0]   rd;
      logic              we;
   } ent_t;

   logic              clock;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic [DATA_W-1:0] in_result;
   logic [DATA_W-1:0] in_read_data;
   logic [RD_W-1:0]   in_rd;
   logic              in_mem_to_reg;
   logic              in_reg_write;
   logic              out_ready;

   int n_cmp = 0;
   int n_err = 0;

   ent_t m1[$];
   ent_t m0[$];

   wb_stage_buffer_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus1 ();
   wb_stage_buffer_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus0 ();

   assign bus1.in_valid      = in_valid;
   assign bus1.in_result     = in_result;
   assign bus1.in_read_data  = in_read_data;
   assign bus1.in_rd         = in_rd;
   assign bus1.in_mem_to_reg = in_mem_to_reg;
   assign bus1.in_reg_write  = in_reg_write;
   assign bus1.out_ready     = out_ready;
   assign bus0.in_valid      = in_valid;
   assign bus0.in_result     = in_result;
   assign bus0.in_read_data  = in_read_data;
   assign bus0.in_rd         = in_rd;
   assign bus0.in_mem_to_reg = in_mem_to_reg;
   assign bus0.in_reg_write  = in_reg_write;
   assign bus0.out_ready     = out_ready;

   wb_stage_buffer #(.DATA_W(DATA_W), .RD_W(RD_W), .SKID(1'b1)) dut1 (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus1.slave)
   );

   wb_stage_buffer #(.DATA_W(DATA_W), .RD_W(RD_W), .SKID(1'b0)) dut0 (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus0.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic ent_t make_ent();
      ent_t e;
      e.data = in_mem_to_reg ? in_read_data : in_result;
      e.rd   = in_rd;
      e.we   = in_reg_write && (in_rd != 0);
      return e;
   endfunction

   // Reference model: capacity-limited FIFOs stepped on every edge.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m1.delete();
         m0.delete();
      end else begin
         bit rdy1, rdy0, cons1, cons0;
         ent_t e;
         e     = make_ent();
         rdy1  = (m1.size() < 2);
         rdy0  = (m0.size() == 0) || out_ready;
         cons1 = (m1.size() > 0) && out_ready;
         cons0 = (m0.size() > 0) && out_ready;
         if (flush) begin
            m1.delete();
            m0.delete();
         end else begin
            if (cons1) void'(m1.pop_front());
            if (in_valid && rdy1) m1.push_back(e);
            if (cons0) void'(m0.pop_front());
            if (in_valid && rdy0) m0.push_back(e);
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clock) begin
      check("skid.out_valid", 64'(bus1.out_valid), 64'(m1.size() > 0));
      check("skid.in_ready", 64'(bus1.in_ready), 64'(m1.size() < 2));
      if (m1.size() > 0) begin
         check("skid.out_wb_data", 64'(bus1.out_wb_data), 64'(m1[0].data));
         check("skid.out_rd", 64'(bus1.out_rd), 64'(m1[0].rd));
         check("skid.out_reg_write", 64'(bus1.out_reg_write), 64'(m1[0].we));
      end else begin
         check("skid.out_reg_write", 64'(bus1.out_reg_write), 64'd0);
      end
      check("reg.out_valid", 64'(bus0.out_valid), 64'(m0.size() > 0));
      check("reg.in_ready", 64'(bus0.in_ready), 64'((m0.size() == 0) || out_ready));
      if (m0.size() > 0) begin
         check("reg.out_wb_data", 64'(bus0.out_wb_data), 64'(m0[0].data));
         check("reg.out_rd", 64'(bus0.out_rd), 64'(m0[0].rd));
         check("reg.out_reg_write", 64'(bus0.out_reg_write), 64'(m0[0].we));
      end else begin
         check("reg.out_reg_write", 64'(bus0.out_reg_write), 64'd0);
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input logic [DATA_W-1:0] res, input logic [DATA_W-1:0] rdat,
                        input logic [RD_W-1:0] rd, input logic m2r, input logic rw);
      in_valid      = 1'b1;
      in_result     = res;
      in_read_data  = rdat;
      in_rd         = rd;
      in_mem_to_reg = m2r;
      in_reg_write  = rw;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".skid.out_valid"}, 64'(bus1.out_valid), 64'd0);
      check({tag, ".skid.out_reg_write"}, 64'(bus1.out_reg_write), 64'd0);
      check({tag, ".skid.out_wb_data"}, 64'(bus1.out_wb_data), 64'd0);
      check({tag, ".skid.out_rd"}, 64'(bus1.out_rd), 64'd0);
      check({tag, ".skid.in_ready"}, 64'(bus1.in_ready), 64'd1);
      check({tag, ".reg.out_valid"}, 64'(bus0.out_valid), 64'd0);
      check({tag, ".reg.out_wb_data"}, 64'(bus0.out_wb_data), 64'd0);
      check({tag, ".reg.in_ready"}, 64'(bus0.in_ready), 64'd1);
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      in_result = '0;
      in_read_data = '0;
      in_rd = '0;
      in_mem_to_reg = 1'b0;
      in_reg_write = 1'b0;
      out_ready = 1'b0;
      #3;
      check_reset_outputs("por");
      #9;
      reset = 1'b0;
      cyc();

      // Load with mem_to_reg selects the read data, visible after one edge.
      out_ready = 1'b1;
      offer(32'h10, 32'hCAFEBABE, 5'd3, 1'b1, 1'b1);
      cyc();
      in_valid = 1'b0;
      check("load.skid.data", 64'(bus1.out_wb_data), 64'hCAFEBABE);
      check("load.skid.rd", 64'(bus1.out_rd), 64'd3);
      check("load.skid.we", 64'(bus1.out_reg_write), 64'd1);
      check("load.reg.data", 64'(bus0.out_wb_data), 64'hCAFEBABE);
      cyc();

      // Register 0 write is suppressed; ALU result is selected.
      out_ready = 1'b0;
      offer(32'h55, 32'hDEAD, 5'd0, 1'b0, 1'b1);
      cyc();
      in_valid = 1'b0;
      check("rd0.skid.valid", 64'(bus1.out_valid), 64'd1);
      check("rd0.skid.we", 64'(bus1.out_reg_write), 64'd0);
      check("rd0.skid.data", 64'(bus1.out_wb_data), 64'h55);
      out_ready = 1'b1;
      cyc();

      // Skid fill and in-order drain of A, B, C.
      out_ready = 1'b0;
      offer(32'hA, 32'h0, 5'd1, 1'b0, 1'b1);
      cyc();
      offer(32'hB, 32'h0, 5'd2, 1'b0, 1'b1);
      cyc();
      offer(32'hC, 32'h0, 5'd4, 1'b0, 1'b1);
      cyc();
      check("abc.full.ready", 64'(bus1.in_ready), 64'd0);
      check("abc.full.head", 64'(bus1.out_wb_data), 64'hA);
      out_ready = 1'b1;
      cyc();
      check("abc.second", 64'(bus1.out_wb_data), 64'hB);
      cyc();
      in_valid = 1'b0;
      check("abc.third", 64'(bus1.out_wb_data), 64'hC);
      check("abc.third.rd", 64'(bus1.out_rd), 64'd4);
      cyc();
      check("abc.empty", 64'(bus1.out_valid), 64'd0);

      // Flush of a full buffer also drops the same-cycle offer.
      out_ready = 1'b0;
      offer(32'hD, 32'h0, 5'd5, 1'b0, 1'b1);
      cyc();
      offer(32'hE, 32'h0, 5'd6, 1'b0, 1'b1);
      cyc();
      flush = 1'b1;
      offer(32'hF, 32'h0, 5'd7, 1'b0, 1'b1);
      cyc();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush.skid.valid", 64'(bus1.out_valid), 64'd0);
      check("flush.skid.ready", 64'(bus1.in_ready), 64'd1);
      check("flush.reg.valid", 64'(bus0.out_valid), 64'd0);
      out_ready = 1'b1;
      repeat (3) cyc();

      // Asynchronous reset while full clears outputs before the next edge.
      out_ready = 1'b0;
      offer(32'h11, 32'h0, 5'd8, 1'b0, 1'b1);
      cyc();
      offer(32'h22, 32'h0, 5'd9, 1'b0, 1'b1);
      cyc();
      in_valid = 1'b0;
      check("prereset.we", 64'(bus1.out_reg_write), 64'd1);
      #1 reset = 1'b1;
      #1 check_reset_outputs("async");
      #1 reset = 1'b0;

      // First accept after reset behaves as on an empty buffer.
      out_ready = 1'b1;
      offer(32'h77, 32'h88, 5'd10, 1'b1, 1'b0);
      cyc();
      in_valid = 1'b0;
      check("post.skid.data", 64'(bus1.out_wb_data), 64'h88);
      check("post.skid.we", 64'(bus1.out_reg_write), 64'd0);
      cyc();

      // Continuous stream with out_ready high: no bubbles.
      for (int i = 0; i < 6; i++) begin
         offer(32'h100 + 32'(i), 32'h0, 5'(i + 1), 1'b0, 1'b1);
         cyc();
         check("stream.reg.valid", 64'(bus0.out_valid), 64'd1);
         check("stream.reg.data", 64'(bus0.out_wb_data), 64'h100 + 64'(i));
         check("stream.skid.data", 64'(bus1.out_wb_data), 64'h100 + 64'(i));
      end
      in_valid = 1'b0;
      cyc();

      // Mixed backpressure pattern, checked by the model only.
      for (int i = 0; i < 60; i++) begin
         out_ready = ((i % 3) != 0);
         flush     = (i == 31);
         if ((i % 4) != 1)
            offer(32'h200 + 32'(i), 32'h300 + 32'(i), 5'(i), 1'((i % 2)), 1'((i % 5) != 0));
         else
            in_valid = 1'b0;
         cyc();
      end
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
